sprite_port_arbiter: RTL and testbench

//  Shares the single graphics sprite-draw port between NUM_REQ requesters
//  (game processor, player-A cursor, player-B cursor, ...) using round-robin arbitration.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/sprite_port_arbiter.sv | 97 +++++++++
 tb/tb_sprite_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite request types and coordinate widths for the sprite draw path.
// Reused by graphics and the processor-side requesters.
package sprite_pkg;
  localparam int CANVAS_WIDTH  = 360;
  localparam int CANVAS_HEIGHT = 720;
  localparam int NUM_FRAMES    = 24;

  localparam int X_W = $clog2(CANVAS_WIDTH);
  localparam int Y_W = $clog2(CANVAS_HEIGHT);
  localparam int F_W = $clog2(NUM_FRAMES);

  typedef struct packed {
    logic [F_W-1:0] frame;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } sprite_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
// The pointer itself lives in the parent so this block holds no state.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_any
);
  logic w_found;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_found && i_req[j]) begin
        w_found     = 1'b1;
        o_grant[j]  = 1'b1;
        o_grant_idx = IW'(j);
      end
    end
  end

  assign o_any = w_found;
endmodule

// File: rtl/sprite_port_arbiter.sv
// Shares the sprite-draw port between NUM_REQ requesters with round-robin grant,
// a one-entry output slot and a per-video-frame sprite budget.
module sprite_port_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int MAX_SPRITES = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(MAX_SPRITES + 1)
) (
  input  logic                   clk_pixel_in,
  input  logic                   rst_n_in,
  input  logic                   new_frame_in,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  input  logic [NUM_REQ*X_W-1:0] req_x_in,
  input  logic [NUM_REQ*Y_W-1:0] req_y_in,
  input  logic [NUM_REQ*F_W-1:0] req_frame_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  output logic                   sprite_valid_out,
  output logic [X_W-1:0]         sprite_x_out,
  output logic [Y_W-1:0]         sprite_y_out,
  output logic [F_W-1:0]         sprite_frame_out,
  input  logic                   sprite_ready_in,
  output logic                   budget_full_out,
  output logic [7:0]             starved_out
);
  logic               r_valid;
  sprite_req_t        r_slot;
  logic [CW-1:0]      r_count;
  logic               r_budget_full;
  logic [7:0]         r_starved;
  logic [IW-1:0]      r_ptr;

  logic               w_slot_free;
  logic               w_can_accept;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic               w_accept;
  sprite_req_t        w_sel;
  logic [CW-1:0]      w_count_next;

  assign w_slot_free  = !r_valid || sprite_ready_in;
  assign w_can_accept = w_slot_free && (r_count < CW'(MAX_SPRITES));

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req       (req_valid_in & {NUM_REQ{w_can_accept}}),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_accept)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel.frame = req_frame_in[i*F_W +: F_W];
        w_sel.x     = req_x_in[i*X_W +: X_W];
        w_sel.y     = req_y_in[i*Y_W +: Y_W];
      end
    end
  end

  // A new frame re-arms the budget but an accept in the same cycle still counts.
  assign w_count_next = (new_frame_in ? '0 : r_count) + CW'(w_accept);

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid       <= 1'b0;
      r_slot        <= '0;
      r_count       <= '0;
      r_budget_full <= 1'b0;
      r_starved     <= '0;
      r_ptr         <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_slot  <= w_sel;
        r_ptr   <= (w_grant_idx == IW'(NUM_REQ - 1)) ? '0 : w_grant_idx + IW'(1);
      end else if (sprite_ready_in) begin
        r_valid <= 1'b0;
      end
      r_count       <= w_count_next;
      r_budget_full <= (w_count_next == CW'(MAX_SPRITES));
      if (new_frame_in && r_budget_full && (|req_valid_in) && (r_starved != 8'hFF))
        r_starved <= r_starved + 8'd1;
    end
  end

  assign req_ready_out    = w_grant;
  assign sprite_valid_out = r_valid;
  assign sprite_x_out     = r_slot.x;
  assign sprite_y_out     = r_slot.y;
  assign sprite_frame_out = r_slot.frame;
  assign budget_full_out  = r_budget_full;
  assign starved_out      = r_starved;
endmodule

// File: tb/tb_sprite_port_arbiter.sv
// Bench for sprite_port_arbiter: directed scenarios then random traffic against a
// cycle-level reference model of the grant, slot, budget and starvation rules.
module tb_sprite_port_arbiter;
  import sprite_pkg::*;

  localparam int NR   = 3;
  localparam int MAXS = 4;

  logic               clk_pixel_in;
  logic               rst_n_in;
  logic               new_frame_in;
  logic [NR-1:0]      req_valid_in;
  logic [NR*X_W-1:0]  req_x_in;
  logic [NR*Y_W-1:0]  req_y_in;
  logic [NR*F_W-1:0]  req_frame_in;
  logic [NR-1:0]      req_ready_out;
  logic               sprite_valid_out;
  logic [X_W-1:0]     sprite_x_out;
  logic [Y_W-1:0]     sprite_y_out;
  logic [F_W-1:0]     sprite_frame_out;
  logic               sprite_ready_in;
  logic               budget_full_out;
  logic [7:0]         starved_out;

  sprite_port_arbiter #(.NUM_REQ(NR), .MAX_SPRITES(MAXS)) dut (
    .clk_pixel_in     (clk_pixel_in),
    .rst_n_in         (rst_n_in),
    .new_frame_in     (new_frame_in),
    .req_valid_in     (req_valid_in),
    .req_x_in         (req_x_in),
    .req_y_in         (req_y_in),
    .req_frame_in     (req_frame_in),
    .req_ready_out    (req_ready_out),
    .sprite_valid_out (sprite_valid_out),
    .sprite_x_out     (sprite_x_out),
    .sprite_y_out     (sprite_y_out),
    .sprite_frame_out (sprite_frame_out),
    .sprite_ready_in  (sprite_ready_in),
    .budget_full_out  (budget_full_out),
    .starved_out      (starved_out)
  );

  initial clk_pixel_in = 1'b0;
  always #5 clk_pixel_in = ~clk_pixel_in;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_count, m_ptr, m_starved;
  bit m_valid;
  int m_x, m_y, m_f;
  bit pend [NR];
  int px [NR];
  int py [NR];
  int pf [NR];
  int dut_grant;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic arm(input int i);
    if (!pend[i]) begin
      pend[i] = 1'b1;
      px[i] = $urandom_range(0, (1 << X_W) - 1);
      py[i] = $urandom_range(0, (1 << Y_W) - 1);
      pf[i] = $urandom_range(0, (1 << F_W) - 1);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      req_valid_in[i]              = pend[i];
      req_x_in[i*X_W +: X_W]       = px[i][X_W-1:0];
      req_y_in[i*Y_W +: Y_W]       = py[i][Y_W-1:0];
      req_frame_in[i*F_W +: F_W]   = pf[i][F_W-1:0];
    end
  endtask

  function automatic bit any_pend();
    bit a = 1'b0;
    for (int i = 0; i < NR; i++) a |= pend[i];
    return a;
  endfunction

  // One clock: drive at negedge, check grant, advance model at posedge, check outputs at negedge.
  task automatic step(input bit nf, input bit srdy);
    int eg;
    int exp_rdy;
    new_frame_in    = nf;
    sprite_ready_in = srdy;
    drive_reqs();
    #1;
    eg = -1;
    if ((!m_valid || srdy) && m_count < MAXS)
      for (int k = 0; k < NR; k++) begin
        int j = (m_ptr + k) % NR;
        if (eg < 0 && pend[j]) eg = j;
      end
    exp_rdy = (eg >= 0) ? (1 << eg) : 0;
    check_val("req_ready", int'(req_ready_out), exp_rdy);
    dut_grant = -1;
    for (int i = 0; i < NR; i++) if (req_ready_out[i]) dut_grant = i;
    @(posedge clk_pixel_in);
    if (nf && m_count == MAXS && any_pend() && m_starved < 255) m_starved++;
    m_count = (nf ? 0 : m_count) + ((eg >= 0) ? 1 : 0);
    if (eg >= 0) begin
      m_valid = 1'b1;
      m_x = px[eg]; m_y = py[eg]; m_f = pf[eg];
      m_ptr = (eg + 1) % NR;
      pend[eg] = 1'b0;
    end else if (srdy) begin
      m_valid = 1'b0;
    end
    @(negedge clk_pixel_in);
    check_val("sprite_valid", int'(sprite_valid_out), int'(m_valid));
    if (m_valid) begin
      check_val("sprite_x", int'(sprite_x_out), m_x);
      check_val("sprite_y", int'(sprite_y_out), m_y);
      check_val("sprite_frame", int'(sprite_frame_out), m_f);
    end
    check_val("budget_full", int'(budget_full_out), (m_count == MAXS) ? 1 : 0);
    check_val("starved", int'(starved_out), m_starved);
  endtask

  task automatic model_reset();
    m_count = 0; m_ptr = 0; m_starved = 0; m_valid = 1'b0;
    m_x = 0; m_y = 0; m_f = 0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NR; i++) begin pend[i] = 1'b0; px[i] = 0; py[i] = 0; pf[i] = 0; end
    rst_n_in = 1'b0;
    new_frame_in = 1'b0;
    sprite_ready_in = 1'b0;
    drive_reqs();
    repeat (3) @(negedge clk_pixel_in);
    check_val("rst_valid", int'(sprite_valid_out), 0);
    check_val("rst_ready", int'(req_ready_out), 0);
    check_val("rst_x", int'(sprite_x_out), 0);
    check_val("rst_budget", int'(budget_full_out), 0);
    check_val("rst_starved", int'(starved_out), 0);
    rst_n_in = 1'b1;

    // round robin with all requesters busy; new_frame at count 3 still lets the accept in
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NR; i++) arm(i);
      step(c == 3, 1'b1);
      check_val("rr_seq", dut_grant, c % NR);
    end

    // single requester, one sprite per cycle; accept alongside new_frame at count 2
    arm(0); step(1'b1, 1'b1);
    arm(0); step(1'b0, 1'b1);
    arm(0); step(1'b1, 1'b1);
    check_val("nf_accept_grant", dut_grant, 0);

    // stall: slot held, no grants, new_frame mid-stall does not flush
    arm(1); arm(2);
    for (int c = 0; c < 5; c++) step(c == 2, 1'b0);
    step(1'b0, 1'b1);
    check_val("stall_release_grant", dut_grant, 1);

    // budget exhaustion with req0 held, then starvation on the next frame
    step(1'b1, 1'b1);
    for (int c = 0; c < 6; c++) begin
      arm(0);
      step(1'b0, 1'b1);
    end
    check_val("budget_full_hold", int'(budget_full_out), 1);
    arm(0);
    step(1'b1, 1'b1);
    check_val("starved_after_nf", int'(starved_out), 1);
    step(1'b0, 1'b1);
    check_val("post_frame_grant", dut_grant, 0);

    // asynchronous reset while the slot is full
    arm(0); arm(1); arm(2);
    drive_reqs();
    check_val("pre_reset_valid", int'(sprite_valid_out), 1);
    #2 rst_n_in = 1'b0;
    #1;
    check_val("async_rst_valid", int'(sprite_valid_out), 0);
    check_val("async_rst_starved", int'(starved_out), 0);
    @(negedge clk_pixel_in);
    rst_n_in = 1'b1;
    model_reset();
    step(1'b0, 1'b1);
    check_val("post_reset_grant", dut_grant, 0);

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++) if ($urandom_range(0, 2) == 0) arm(i);
      step($urandom_range(0, 11) == 0, $urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
